mem_stage_lsu: RTL and testbench

- Memory-stage load/store unit of the pipelined RV32I core.
- Consumes the EX/MEM register's outputs: memory write/read control, ALU result as the address, store data and funct3.
- Acts as the initiator on a req/gnt/rvalid data-memory port and produces byte-lane-aligned stores and sign/zero-extended load data.
- Stalls the pipeline until each access completes.

---
 rtl/riscv_configs.sv | 49 ++++
 rtl/mem_stage_lsu_if.sv | 23 ++
 rtl/mem_stage_lsu_align.sv | 46 ++++
 rtl/mem_stage_lsu.sv | 167 ++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_configs.sv
// Shared RV32I definitions for the memory stage: XLEN, funct3 load/store
// encodings, LSU FSM state encoding and access-size helpers.
`ifndef XLEN
`define XLEN 32
`endif

package riscv_configs;

    localparam int XLEN_P = `XLEN;

    // funct3 encodings shared by loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT_R = 2'd2,
        ST_DONE   = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    // funct3[1:0] selects the size; the unused encodings fall back to word
    function automatic lsu_size_e f3_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return SZ_B;
            2'b01:   return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

    // A halfword must sit on an even address, a word on a multiple of four
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3_size(f3))
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            default: return (off != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory req/gnt/rvalid port. The LSU is the master, memory the slave.
interface mem_stage_lsu_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [3:0]      be;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane steering: store byte enables and replicated store data, plus
// extraction and sign/zero extension of load data. Purely combinational.
module lsu_align
    import riscv_configs::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_off,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [XLEN-1:0] i_rdata,
    output logic [3:0]      o_be,
    output logic [XLEN-1:0] o_wdata,
    output logic [XLEN-1:0] o_rdata
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        is_signed;

    // Lane selection; halfwords use only off[1], so an odd address truncates
    always_comb begin
        byte_sel  = i_rdata[8*i_off +: 8];
        half_sel  = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
        is_signed = ~i_funct3[2];
        o_be      = 4'b1111;
        o_wdata   = i_wdata;
        o_rdata   = i_rdata;
        case (f3_size(i_funct3))
            SZ_B: begin
                o_be    = 4'b0001 << i_off;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{(XLEN-8){is_signed & byte_sel[7]}}, byte_sel};
            end
            SZ_H: begin
                o_be    = i_off[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {{(XLEN-16){is_signed & half_sel[15]}}, half_sel};
            end
            default: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
                o_rdata = i_rdata;
            end
        endcase
    end
endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: issues one req/gnt/rvalid access per
// memory instruction and stalls the pipeline until it completes.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned H/W accesses skip
// the bus and raise o_misalign for one cycle instead of truncating.
module mem_stage_lsu
    import riscv_configs::*;
#(
    parameter int XLEN = `XLEN
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    input  logic            i_mem_write,
    input  logic            i_mem_read,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_wdata,
    output logic            o_stall,
    output logic [XLEN-1:0] o_rdata,
    output logic            o_rdata_valid,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic            o_misalign,
`endif
    mem_stage_lsu_if.master dmem
);
    lsu_state_e      state_q, state_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [3:0]      be_q, be_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [1:0]      off_q, off_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            rdata_valid_q, rdata_valid_d;
    logic            misalign_q, misalign_d;

    logic            start;
    logic            in_idle;
    logic [2:0]      al_funct3;
    logic [1:0]      al_off;
    logic [3:0]      al_be;
    logic [XLEN-1:0] al_wdata;
    logic [XLEN-1:0] al_rdata;

    assign start   = i_valid & (i_mem_write | i_mem_read);
    assign in_idle = (state_q == ST_IDLE);

    // One aligner serves both paths: in IDLE it shapes the incoming store,
    // afterwards it extracts the load using the latched funct3/offset.
    assign al_funct3 = in_idle ? i_funct3 : funct3_q;
    assign al_off    = in_idle ? i_addr[1:0] : off_q;

    lsu_align #(.XLEN(XLEN)) u_align (
        .i_funct3 (al_funct3),
        .i_off    (al_off),
        .i_wdata  (i_wdata),
        .i_rdata  (dmem.rdata),
        .o_be     (al_be),
        .o_wdata  (al_wdata),
        .o_rdata  (al_rdata)
    );

    // Next-state and registered-output logic for the access sequencer
    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        be_d          = be_q;
        funct3_d      = funct3_q;
        off_d         = off_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        misalign_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    we_d     = i_mem_write;   // a write wins over a simultaneous read
                    addr_d   = {i_addr[XLEN-1:2], 2'b00};
                    wdata_d  = al_wdata;
                    be_d     = al_be;
                    funct3_d = i_funct3;
                    off_d    = i_addr[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
                    if (is_misaligned(i_funct3, i_addr[1:0])) begin
                        state_d    = ST_DONE;
                        misalign_d = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                        req_d   = 1'b1;
                    end
`else
                    state_d = ST_REQ;
                    req_d   = 1'b1;
`endif
                end
            end
            ST_REQ: begin
                if (dmem.gnt) begin
                    req_d   = 1'b0;
                    state_d = we_q ? ST_DONE : ST_WAIT_R;
                end
            end
            ST_WAIT_R: begin
                if (dmem.rvalid) begin
                    rdata_d       = al_rdata;
                    rdata_valid_d = 1'b1;
                    state_d       = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight access
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= ST_IDLE;
            req_q         <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            be_q          <= 4'b0000;
            funct3_q      <= 3'b000;
            off_q         <= 2'b00;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            be_q          <= be_d;
            funct3_q      <= funct3_d;
            off_q         <= off_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            misalign_q    <= misalign_d;
        end
    end

    assign o_stall = (in_idle & start) | (state_q == ST_REQ) | (state_q == ST_WAIT_R);

    assign dmem.req      = req_q;
    assign dmem.we       = we_q;
    assign dmem.addr     = addr_q;
    assign dmem.wdata    = wdata_q;
    assign dmem.be       = be_q;
    assign o_rdata       = rdata_q;
    assign o_rdata_valid = rdata_valid_q;
`ifdef LSU_MISALIGN_TRAP_EN
    assign o_misalign    = misalign_q;
`else
    logic unused_misalign;
    assign unused_misalign = misalign_q;
`endif
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: expected bus requests and load
// results are queued at issue time and checked by an independent monitor.
module tb_mem_stage_lsu;

    logic        clk;
    logic        rst;
    logic        valid;
    logic        mw;
    logic        mr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdv;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    mem_stage_lsu_if #(.XLEN(32)) dmem ();

    mem_stage_lsu #(.XLEN(32)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_valid       (valid),
        .i_mem_write   (mw),
        .i_mem_read    (mr),
        .i_funct3      (f3),
        .i_addr        (addr),
        .i_wdata       (wdata),
        .o_stall       (stall),
        .o_rdata       (rdata),
        .o_rdata_valid (rdv),
`ifdef LSU_MISALIGN_TRAP_EN
        .o_misalign    (misalign),
`endif
        .dmem          (dmem)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          req_cycles;
    } req_t;

    req_t        exp_req_q[$];
    logic [31:0] exp_rd_q[$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_req(input logic we, input logic [31:0] a, input logic [3:0] be,
                            input logic [31:0] wd, input int cyc);
        req_t e;
        e.we = we; e.addr = a; e.be = be; e.wdata = wd; e.req_cycles = cyc;
        exp_req_q.push_back(e);
    endtask

    // ---------------- memory responder ----------------
    int          gnt_wait = 0;
    int          rv_delay = 0;
    bit          hold_hi  = 0;
    logic [31:0] mem [0:1023];
    bit          granted_last = 0;
    logic        g_we;
    logic [31:0] g_addr;
    logic [31:0] g_wd;
    logic [3:0]  g_be;
    bit          rv_arm = 0;
    int          rv_cnt = 0;
    logic [31:0] rv_addr = 32'h0;
    int          req_cnt = 0;

    initial begin : responder
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        dmem.gnt    = 1'b0;
        dmem.rvalid = 1'b0;
        dmem.rdata  = 32'h0;
        forever begin
            @(negedge clk);
            if (granted_last) begin
                if (g_we) begin
                    for (int b = 0; b < 4; b++)
                        if (g_be[b]) mem[g_addr[11:2]][8*b +: 8] = g_wd[8*b +: 8];
                end else begin
                    rv_arm  = 1;
                    rv_cnt  = rv_delay;
                    rv_addr = g_addr;
                end
                granted_last = 0;
            end
            dmem.rvalid = hold_hi;
            if (rv_arm) begin
                if (rv_cnt == 0) begin
                    dmem.rvalid = 1'b1;
                    rv_arm      = 0;
                end else begin
                    rv_cnt--;
                end
            end
            dmem.rdata = mem[rv_addr[11:2]];
            if (dmem.req === 1'b1) begin
                dmem.gnt = hold_hi || (req_cnt >= gnt_wait);
                req_cnt++;
            end else begin
                dmem.gnt = hold_hi;
                req_cnt  = 0;
            end
            if (dmem.req === 1'b1 && dmem.gnt) begin
                granted_last = 1;
                g_we   = dmem.we;
                g_addr = dmem.addr;
                g_wd   = dmem.wdata;
                g_be   = dmem.be;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        int          run;
        bit          stable;
        logic        f_we;
        logic [31:0] f_addr;
        logic [31:0] f_wd;
        logic [3:0]  f_be;
        req_t        e;
        logic [31:0] er;
        run    = 0;
        stable = 1;
        forever begin
            @(negedge clk);
            #1;
            if (dmem.req === 1'b1) begin
                if (run == 0) begin
                    f_we = dmem.we; f_addr = dmem.addr; f_wd = dmem.wdata; f_be = dmem.be;
                    stable = 1;
                end else if (dmem.we !== f_we || dmem.addr !== f_addr ||
                             dmem.wdata !== f_wd || dmem.be !== f_be) begin
                    stable = 0;
                end
                run++;
                if (dmem.gnt === 1'b1) begin
                    if (exp_req_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_req: addr %h we %b, none expected", dmem.addr, dmem.we);
                    end else begin
                        e = exp_req_q.pop_front();
                        check32("req_we", {31'b0, dmem.we}, {31'b0, e.we});
                        check32("req_addr", dmem.addr, e.addr);
                        check32("req_be", {28'b0, dmem.be}, {28'b0, e.be});
                        if (e.we) check32("req_wdata", dmem.wdata, e.wdata);
                        check32("req_cycles", run, e.req_cycles);
                        check32("req_stable", {31'b0, stable}, 32'd1);
                    end
                    run = 0;
                end
            end else begin
                run = 0;
            end
            if (rdv === 1'b1) begin
                if (exp_rd_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_rdata_valid: rdata %h, none expected", rdata);
                end else begin
                    er = exp_rd_q.pop_front();
                    check32("load_rdata", rdata, er);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_op(input logic w, input logic r, input logic [2:0] fn,
                          input logic [31:0] a, input logic [31:0] wd, output int stalls);
        int n;
        @(negedge clk);
        valid = 1'b1; mw = w; mr = r; f3 = fn; addr = a; wdata = wd;
        stalls = 0;
        n = 0;
        #1;
        while (stall === 1'b1 && n < 40) begin
            stalls++;
            n++;
            @(negedge clk);
            #1;
        end
        if (stall !== 1'b0) begin
            vectors++;
            miscompares++;
            $display("FAIL op_timeout: addr %h still stalled after %0d cycles, required completion", a, n);
        end
    endtask

    task automatic go_idle();
        @(negedge clk);
        valid = 1'b0; mw = 1'b0; mr = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int st;
        rst = 1'b1; valid = 1'b0; mw = 1'b0; mr = 1'b0; f3 = 3'b000; addr = 32'h0; wdata = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        check32("rst_req", {31'b0, dmem.req}, 32'd0);
        check32("rst_we", {31'b0, dmem.we}, 32'd0);
        check32("rst_addr", dmem.addr, 32'h0);
        check32("rst_wdata", dmem.wdata, 32'h0);
        check32("rst_be", {28'b0, dmem.be}, 32'h0);
        check32("rst_rdata", rdata, 32'h0);
        check32("rst_rdata_valid", {31'b0, rdv}, 32'd0);
        check32("rst_stall", {31'b0, stall}, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
        check32("rst_misalign", {31'b0, misalign}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // SB to 0x103: lane 3, replicated byte
        push_req(1'b1, 32'h100, 4'b1000, 32'hABABABAB, 1);
        run_op(1'b1, 1'b0, 3'b000, 32'h103, 32'h000000AB, st);
        check32("sb_stall_cycles", st, 2);
        go_idle();

        // LB / LBU at 0x102 of 0x00800000
        mem[32'h100 >> 2] = 32'h00800000;
        push_req(1'b0, 32'h100, 4'b0100, 32'h0, 1);
        exp_rd_q.push_back(32'hFFFFFF80);
        run_op(1'b0, 1'b1, 3'b000, 32'h102, 32'h0, st);
        check32("lb_stall_cycles", st, 3);
        push_req(1'b0, 32'h100, 4'b0100, 32'h0, 1);
        exp_rd_q.push_back(32'h00000080);
        run_op(1'b0, 1'b1, 3'b100, 32'h102, 32'h0, st);
        check32("lbu_stall_cycles", st, 3);
        go_idle();
        repeat (3) @(negedge clk);
        #1;
        check32("rdata_hold", rdata, 32'h00000080);

        // LHU at 0x202 with grant delayed three cycles
        mem[32'h200 >> 2] = 32'hBEEF1234;
        gnt_wait = 3;
        push_req(1'b0, 32'h200, 4'b1100, 32'h0, 4);
        exp_rd_q.push_back(32'h0000BEEF);
        run_op(1'b0, 1'b1, 3'b101, 32'h202, 32'h0, st);
        check32("lhu_stall_cycles", st, 6);
        gnt_wait = 0;

        // LH signed, both halves
        push_req(1'b0, 32'h200, 4'b0011, 32'h0, 1);
        exp_rd_q.push_back(32'h00001234);
        run_op(1'b0, 1'b1, 3'b001, 32'h200, 32'h0, st);
        push_req(1'b0, 32'h200, 4'b1100, 32'h0, 1);
        exp_rd_q.push_back(32'hFFFFBEEF);
        run_op(1'b0, 1'b1, 3'b001, 32'h202, 32'h0, st);

        // SH upper half; write wins over simultaneous read
        push_req(1'b1, 32'h104, 4'b1100, 32'hBEEFBEEF, 1);
        run_op(1'b1, 1'b1, 3'b001, 32'h106, 32'h1234BEEF, st);
        check32("sh_stall_cycles", st, 2);
        go_idle();

        // Reset while waiting for read data
        rv_delay = 3;
        push_req(1'b0, 32'h300, 4'b1111, 32'h0, 1);
        @(negedge clk);
        valid = 1'b1; mw = 1'b0; mr = 1'b1; f3 = 3'b010; addr = 32'h300; wdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check32("waitr_stall", {31'b0, stall}, 32'd1);
        rst = 1'b1; valid = 1'b0; mr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check32("abort_req", {31'b0, dmem.req}, 32'd0);
        check32("abort_stall", {31'b0, stall}, 32'd0);
        repeat (5) @(negedge clk);
        #1;
        check32("abort_rdata", rdata, 32'h0);
        check32("abort_rdata_valid", {31'b0, rdv}, 32'd0);
        rv_delay = 0;

        // Back-to-back SW then LW with gnt/rvalid held high
        hold_hi = 1;
        push_req(1'b1, 32'h10, 4'b1111, 32'hCAFEF00D, 1);
        push_req(1'b0, 32'h10, 4'b1111, 32'h0, 1);
        exp_rd_q.push_back(32'hCAFEF00D);
        run_op(1'b1, 1'b0, 3'b010, 32'h10, 32'hCAFEF00D, st);
        check32("b2b_sw_stall_cycles", st, 2);
        run_op(1'b0, 1'b1, 3'b010, 32'h10, 32'h0, st);
        check32("b2b_lw_stall_cycles", st, 3);
        go_idle();
        hold_hi = 0;
        repeat (2) @(negedge clk);

        // Misaligned LW at 0x1
        mem[0] = 32'h11223344;
`ifdef LSU_MISALIGN_TRAP_EN
        run_op(1'b0, 1'b1, 3'b010, 32'h1, 32'h0, st);
        check32("mis_stall_cycles", st, 1);
        check32("mis_flag", {31'b0, misalign}, 32'd1);
        go_idle();
        #1;
        check32("mis_flag_clear", {31'b0, misalign}, 32'd0);
        check32("mis_rdata_unchanged", rdata, 32'hCAFEF00D);
`else
        push_req(1'b0, 32'h0, 4'b1111, 32'h0, 1);
        exp_rd_q.push_back(32'h11223344);
        run_op(1'b0, 1'b1, 3'b010, 32'h1, 32'h0, st);
        check32("mis_trunc_stall_cycles", st, 3);
        go_idle();
`endif

        repeat (6) @(negedge clk);
        #2;
        check32("pending_req_expectations", exp_req_q.size(), 0);
        check32("pending_rdata_expectations", exp_rd_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
